// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage of the five-stage ARM-subset pipeline. It owns the
// program counter and fetches from instruction memory over a req/ack
// handshake that tolerates wait states. A one-entry skid buffer catches a
// word that returns while decode is frozen. The stage drives the IF/ID
// register. Branch redirects from execute flush IF/ID and retarget fetch.
// If a redirect arrives while a request is still waiting for its ack, that
// request is drained and its data is discarded.
//
// Ports
//   clk                  rising-edge clock
//   rst                  synchronous active-high reset
//   i_freeze             hazard stall; IF/ID holds
//   i_branch_taken       redirect request from execute
//   i_branch_addr[31:0]  redirect target (word aligned)
//   o_imem_req           fetch request (held until ack)
//   o_imem_addr[31:0]    fetch address, stable while o_imem_req waits
//   i_imem_ack           response valid while o_imem_req is high
//   i_imem_rdata[31:0]   fetched word
//   o_if_valid           IF/ID holds a real instruction
//   o_if_pc[31:0]        fetch address + 4 of the IF/ID instruction
//   o_if_instruction     IF/ID instruction word, NOP_INSTR on bubbles
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_freeze,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_addr,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_if_valid,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_instruction
);

  // S_REQ   : request to r_pc on the bus
  // S_FULL  : skid buffer holds a word; bus idle
  // S_DRAIN : stale request to r_stale_addr still on the bus; r_pc is the
  //           branch target to fetch once the stale ack arrives
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_FULL  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] r_stale_addr;
  logic [31:0] w_stale_addr_next;
  logic [31:0] r_skid_pc;
  logic [31:0] w_skid_pc_next;
  logic [31:0] r_skid_instr;
  logic [31:0] w_skid_instr_next;
  logic        r_if_valid;
  logic        w_if_valid_next;
  logic [31:0] r_if_pc;
  logic [31:0] w_if_pc_next;
  logic [31:0] r_if_instr;
  logic [31:0] w_if_instr_next;
  logic [31:0] w_pc_inc;

  // Bus outputs come from registered state only. rst gating drops the
  // request immediately, which abandons any outstanding fetch.
  assign o_imem_req  = !rst && (r_state != S_FULL);
  assign o_imem_addr = (r_state == S_DRAIN) ? r_stale_addr : r_pc;

  // Wraps modulo 2^32 from 32'hFFFF_FFFC to 0.
  assign w_pc_inc = r_pc + 32'd4;

  // NOTE: every signal driven here gets a default first, so a path that does
  // not assign it cannot infer a latch. Blocking assignments are correct
  // inside combinational logic.
  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_stale_addr_next = r_stale_addr;
    w_skid_pc_next    = r_skid_pc;
    w_skid_instr_next = r_skid_instr;
    w_if_valid_next   = r_if_valid;
    w_if_pc_next      = r_if_pc;
    w_if_instr_next   = r_if_instr;

    if (i_branch_taken) begin
      // A redirect flushes IF/ID even when frozen. Leaving S_FULL discards
      // the skid word.
      w_if_valid_next = 1'b0;
      w_if_pc_next    = 32'h0;
      w_if_instr_next = NOP_INSTR;
      w_pc_next       = i_branch_addr;
      if ((r_state != S_FULL) && !i_imem_ack) begin
        // The un-acked request must finish at its original address.
        // A second branch in S_DRAIN keeps that stale address.
        w_state_next = S_DRAIN;
        if (r_state == S_REQ) begin
          w_stale_addr_next = r_pc;
        end
      end else begin
        w_state_next = S_REQ;
      end
    end else begin
      case (r_state)
        S_REQ: begin
          if (i_imem_ack) begin
            w_pc_next = w_pc_inc;
            if (i_freeze) begin
              w_skid_pc_next    = w_pc_inc;
              w_skid_instr_next = i_imem_rdata;
              w_state_next      = S_FULL;
            end else begin
              w_if_valid_next = 1'b1;
              w_if_pc_next    = w_pc_inc;
              w_if_instr_next = i_imem_rdata;
            end
          end else if (!i_freeze) begin
            w_if_valid_next = 1'b0;
            w_if_pc_next    = 32'h0;
            w_if_instr_next = NOP_INSTR;
          end
        end

        S_FULL: begin
          if (!i_freeze) begin
            w_if_valid_next = 1'b1;
            w_if_pc_next    = r_skid_pc;
            w_if_instr_next = r_skid_instr;
            w_state_next    = S_REQ;
          end
        end

        S_DRAIN: begin
          // The returning word belongs to the abandoned path and is dropped.
          if (i_imem_ack) begin
            w_state_next = S_REQ;
          end
          if (!i_freeze) begin
            w_if_valid_next = 1'b0;
            w_if_pc_next    = 32'h0;
            w_if_instr_next = NOP_INSTR;
          end
        end

        default: begin
          w_state_next = S_REQ;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments. Every flop then
  // samples pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_stale_addr <= RESET_PC;
      r_if_valid   <= 1'b0;
      r_if_pc      <= 32'h0;
      r_if_instr   <= NOP_INSTR;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_stale_addr <= w_stale_addr_next;
      r_if_valid   <= w_if_valid_next;
      r_if_pc      <= w_if_pc_next;
      r_if_instr   <= w_if_instr_next;
    end
  end

  // NOTE: the skid data registers have no reset. Their contents are read
  // only in S_FULL, and S_FULL is entered only after they have been loaded.
  always_ff @(posedge clk) begin
    r_skid_pc    <= w_skid_pc_next;
    r_skid_instr <= w_skid_instr_next;
  end

  assign o_if_valid       = r_if_valid;
  assign o_if_pc          = r_if_pc;
  assign o_if_instruction = r_if_instr;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Self-checking bench for if_fetch_unit. A transaction-level model predicts
// the bus request and the IF/ID contents every cycle. Its state is the
// address of the fetch on the bus, a drop flag with a pending target, a
// queue of words waiting for decode, and the current IF/ID entry. Directed
// scenarios carry literal expectations that pin the model. A pseudo-random
// tail mixes branches, freezes, resets and wait states.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_freeze;
  logic        i_branch_taken;
  logic [31:0] i_branch_addr;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic        o_if_valid;
  logic [31:0] o_if_pc;
  logic [31:0] o_if_instruction;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_freeze        (i_freeze),
    .i_branch_taken  (i_branch_taken),
    .i_branch_addr   (i_branch_addr),
    .o_imem_req      (o_imem_req),
    .o_imem_addr     (o_imem_addr),
    .i_imem_ack      (i_imem_ack),
    .i_imem_rdata    (i_imem_rdata),
    .o_if_valid      (o_if_valid),
    .o_if_pc         (o_if_pc),
    .o_if_instruction(o_if_instruction)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;

  ifid_t       m_ifid;
  ifid_t       m_held[$];   // fetched words waiting for decode to unfreeze
  logic [31:0] m_bus_addr;  // address the bus request carries
  logic [31:0] m_target;    // where fetch resumes once a dropped fetch ends
  bit          m_drop;      // current bus fetch belongs to a flushed path

  // Memory responder parameters
  int          waits    = 0;
  int          wait_cnt = 0;
  logic [31:0] mix      = 32'h0;

  function automatic ifid_t bubble();
    ifid_t b;
    b.valid = 1'b0;
    b.pc    = 32'h0;
    b.instr = NOP;
    return b;
  endfunction

  function automatic bit m_req(input bit r);
    return !r && (m_held.size() == 0);
  endfunction

  task automatic model_reset();
    m_ifid     = bubble();
    m_held.delete();
    m_bus_addr = 32'h0;
    m_target   = 32'h0;
    m_drop     = 1'b0;
  endtask

  task automatic model_step(input bit r, input bit f, input bit b, input logic [31:0] ba,
                            input bit ack, input logic [31:0] rd);
    bit    on_bus;
    bit    got;
    ifid_t w;
    on_bus = m_req(r);
    got    = on_bus && ack;
    if (r) begin
      model_reset();
    end else if (b) begin
      m_ifid = bubble();
      m_held.delete();
      if (on_bus && !ack) begin
        m_drop   = 1'b1;
        m_target = ba;
      end else begin
        m_drop     = 1'b0;
        m_bus_addr = ba;
      end
    end else if (m_held.size() != 0) begin
      if (!f) m_ifid = m_held.pop_front();
    end else if (m_drop) begin
      if (got) begin
        m_drop     = 1'b0;
        m_bus_addr = m_target;
      end
      if (!f) m_ifid = bubble();
    end else begin
      if (got) begin
        w.valid    = 1'b1;
        w.pc       = m_bus_addr + 32'd4;
        w.instr    = rd;
        m_bus_addr = m_bus_addr + 32'd4;
        if (f) m_held.push_back(w);
        else   m_ifid = w;
      end else if (!f) begin
        m_ifid = bubble();
      end
    end
  endtask

  // One clock cycle. Inputs are driven at the falling edge. The memory
  // answers, then the visible outputs are compared with the model, and the
  // model advances as the rising edge will.
  task automatic cyc(input bit r, input bit f, input bit b, input logic [31:0] ba);
    bit exp_req;
    bit ack;
    @(negedge clk);
    rst            = r;
    i_freeze       = f;
    i_branch_taken = b;
    i_branch_addr  = ba;
    #1;
    ack          = o_imem_req && (wait_cnt >= waits);
    i_imem_ack   = ack;
    i_imem_rdata = o_imem_addr ^ mix;

    exp_req = m_req(r);
    check("imem_req", {31'h0, o_imem_req}, {31'h0, exp_req});
    if (exp_req) check("imem_addr", o_imem_addr, m_bus_addr);
    check("if_valid", {31'h0, o_if_valid}, {31'h0, m_ifid.valid});
    check("if_pc", o_if_pc, m_ifid.pc);
    check("if_instruction", o_if_instruction, m_ifid.instr);

    model_step(r, f, b, ba, ack, i_imem_rdata);

    if (!o_imem_req || ack) wait_cnt = 0;
    else                    wait_cnt = wait_cnt + 1;
  endtask

  task automatic lit_if(input string name, input bit v, input logic [31:0] pc,
                        input logic [31:0] instr);
    check({name, "_valid"}, {31'h0, o_if_valid}, {31'h0, v});
    check({name, "_pc"}, o_if_pc, pc);
    check({name, "_instr"}, o_if_instruction, instr);
  endtask

  task automatic lit_bus(input string name, input bit req, input logic [31:0] addr);
    check({name, "_req"}, {31'h0, o_imem_req}, {31'h0, req});
    if (req) check({name, "_addr"}, o_imem_addr, addr);
  endtask

  initial begin
    rst            = 1'b1;
    i_freeze       = 1'b0;
    i_branch_taken = 1'b0;
    i_branch_addr  = 32'h0;
    i_imem_ack     = 1'b0;
    i_imem_rdata   = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset values and zero-wait streaming, word = address
    cyc(1, 0, 0, 0);               // reset cycle
    lit_bus("rst", 0, 0);
    lit_if("rst", 0, 32'h0, NOP);
    cyc(0, 0, 0, 0);               // first request
    lit_bus("first", 1, 32'h0);
    lit_if("first", 0, 32'h0, NOP);
    cyc(0, 0, 0, 0);
    lit_if("stream0", 1, 32'h4, 32'h0);
    cyc(0, 0, 0, 0);
    lit_if("stream1", 1, 32'h8, 32'h4);
    cyc(0, 0, 0, 0);
    lit_if("stream2", 1, 32'hC, 32'h8);

    // Freeze in the ack cycle of 0x10, held three cycles
    cyc(0, 1, 0, 0);
    lit_bus("frz_ack", 1, 32'h10);
    cyc(0, 1, 0, 0);
    lit_bus("frz_full", 0, 0);
    lit_if("frz_hold", 1, 32'h10, 32'hC);
    cyc(0, 1, 0, 0);
    lit_if("frz_hold2", 1, 32'h10, 32'hC);
    cyc(0, 0, 0, 0);               // still full, unfreezes at this edge
    lit_bus("frz_full2", 0, 0);

    // Two-wait memory
    waits = 2;
    cyc(0, 0, 0, 0);
    lit_if("unfrz", 1, 32'h14, 32'h10);
    lit_bus("unfrz", 1, 32'h14);
    cyc(0, 0, 0, 0);
    lit_bus("w2_a", 1, 32'h14);
    lit_if("w2_bub0", 0, 32'h0, NOP);
    cyc(0, 0, 0, 0);
    lit_bus("w2_b", 1, 32'h14);
    lit_if("w2_bub1", 0, 32'h0, NOP);
    cyc(0, 0, 0, 0);
    lit_if("w2_word", 1, 32'h18, 32'h14);
    lit_bus("w2_next", 1, 32'h18);
    repeat (6) cyc(0, 0, 0, 0);
    lit_bus("pre_br", 1, 32'h20);

    // Branch to 0x100 while the 0x20 request waits
    cyc(0, 0, 1, 32'h100);
    cyc(0, 0, 0, 0);
    lit_bus("drain_stale", 1, 32'h20);
    cyc(0, 0, 0, 0);
    lit_bus("br_target", 1, 32'h100);
    lit_if("br_bub", 0, 32'h0, NOP);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    waits = 0;
    cyc(0, 1, 0, 0);               // ack of 0x104 lands in the skid
    lit_if("br_word", 1, 32'h104, 32'h100);

    // Branch with freeze and a full skid
    cyc(0, 1, 1, 32'h200);
    cyc(0, 0, 0, 0);
    lit_if("brfrz", 0, 32'h0, NOP);
    lit_bus("brfrz", 1, 32'h200);
    waits = 4;
    cyc(0, 0, 0, 0);
    lit_if("brfrz_word", 1, 32'h204, 32'h200);

    // Second branch and freeze during DRAIN, then reset
    cyc(0, 0, 1, 32'h300);
    cyc(0, 1, 1, 32'h400);
    cyc(0, 1, 0, 0);
    lit_bus("drain_keep", 1, 32'h204);
    lit_if("drain_bub", 0, 32'h0, NOP);
    cyc(1, 0, 0, 0);
    lit_bus("drain_rst", 0, 0);
    waits = 0;
    cyc(0, 0, 0, 0);
    lit_bus("after_rst", 1, 32'h0);
    lit_if("after_rst", 0, 32'h0, NOP);

    // pc wrap at the top of the address space
    cyc(0, 0, 1, 32'hFFFF_FFF8);
    cyc(0, 0, 0, 0);
    lit_bus("wrap_a", 1, 32'hFFFF_FFF8);
    cyc(0, 0, 0, 0);
    lit_if("wrap_a", 1, 32'hFFFF_FFFC, 32'hFFFF_FFF8);
    cyc(0, 0, 0, 0);
    lit_bus("wrap_b", 1, 32'h0);
    lit_if("wrap_b", 1, 32'h0, 32'hFFFF_FFFC);

    // Mixed traffic, data no longer equal to address
    mix = 32'h5A5A_0001;
    for (int i = 0; i < 600; i++) begin
      waits = int'($urandom_range(0, 2));
      cyc($urandom_range(0, 99) == 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 7) == 0,
          {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
    end
    cyc(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage for the five-stage ARM-subset pipeline. It owns the program counter and issues fetch requests to the instruction memory over a req/ack handshake that tolerates wait states. It holds one fetched word in a skid buffer while the decode stage is frozen, and drives the IF/ID pipeline register that supplies `pc` and `instruction` to instruction decode. Branch redirects arriving from execute flush the IF/ID register and retarget fetch, including while a memory request is outstanding.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch address after reset.
- `NOP_INSTR`, 32'hE1A0_0000 (MOV r0,r0), instruction word presented to decode during bubbles.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `freeze` in 1: hazard stall from the hazard unit; IF/ID must hold.
- `branch_taken` in 1: redirect request from execute.
- `branch_addr` in 32: redirect target, byte address with bits [1:0] = 0.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address, word aligned.
- `imem_ack` in 1: response valid; only meaningful while `imem_req` is high.
- `imem_rdata` in 32: fetched word, sampled when `imem_req & imem_ack`.
- `if_valid` out 1: IF/ID holds a real instruction.
- `if_pc` out 32: registered fetch address + 4 of the instruction in IF/ID.
- `if_instruction` out 32: registered instruction word; `NOP_INSTR` when `if_valid` = 0.

## Operation
- The FSM has three states:
  - REQ: `imem_req` = 1, `imem_addr` = pc.
  - FULL: `imem_req` = 0; the skid buffer holds a word.
  - DRAIN: `imem_req` = 1, `imem_addr` = the stale address; the returning response is discarded.
- Handshake: once `imem_req` rises, `imem_addr` stays constant until the cycle in which `imem_ack` = 1. `imem_req` never drops before ack.
- Rule priority per cycle: `rst` > `branch_taken` > `freeze` > normal.
- REQ, ack, no freeze: IF/ID ← {1, pc+4, rdata}; pc ← pc+4; stay in REQ. The next request issues in the following cycle.
- REQ, ack, freeze: skid ← {pc+4, rdata}; pc ← pc+4; go to FULL; IF/ID holds.
- REQ, no ack, no freeze: IF/ID ← bubble {0, 0, NOP_INSTR}.
- REQ, no ack, freeze: IF/ID holds.
- FULL, freeze: everything holds.
- FULL, no freeze: IF/ID ← skid with valid = 1; go to REQ.
- Branch in any state:
  - IF/ID ← bubble, even when frozen; the skid buffer is cleared; pc ← `branch_addr`.
  - Next state is DRAIN if the state is REQ or DRAIN and `imem_ack` = 0 this cycle. Otherwise the next state is REQ.
  - A branch in DRAIN keeps the old stale address and updates only the target.
- DRAIN, ack: discard rdata; go to REQ at the branch target. DRAIN, no ack: stay.
- During DRAIN, IF/ID shows bubbles unless frozen, in which case it holds.
- pc arithmetic is modulo 2^32 and wraps from 32'hFFFF_FFFC to 0. Bits [1:0] of pc are always 0.

## Timing
- Reset values: state = REQ; pc = `RESET_PC`; `imem_req` = 0 during the reset cycle (gated by `rst`); `if_valid` = 0; `if_pc` = 0; `if_instruction` = `NOP_INSTR`; skid empty.
- First request: `imem_req` = 1 in the first cycle after `rst` deasserts.
- Latency: an ack in cycle N makes the word visible on `if_*` in cycle N+1.
- Throughput: with a zero-wait memory (ack in the same cycle as req), one instruction per cycle.
- A branch in cycle N means the request to `branch_addr` is issued in cycle N+1 when no fetch is outstanding. Otherwise it issues one cycle after the stale ack.
- Reset mid-request or in DRAIN/FULL: an outstanding request is abandoned. The memory must tolerate `imem_req` dropping on reset.
- No combinational path from `imem_ack`/`imem_rdata` to `if_*`. `imem_req`/`imem_addr` depend only on registered state and `rst`.

## Test plan
- Zero-wait memory returning word = address, after reset: `if_pc` = 4, 8, 12 … on consecutive cycles; `if_instruction` = 0, 4, 8 …; `if_valid` = 1 from cycle 2.
- Two-wait-state memory: `imem_addr` stays constant for 3 cycles per fetch. `if_valid` pattern is 0,0,1 repeating, with `NOP_INSTR` shown in the bubble cycles.
- Freeze asserted in the ack cycle of word at 0x10 and held for 3 cycles:
  - `imem_req` = 0 during FULL.
  - IF/ID holds its prior value.
  - The cycle after freeze drops, `if_pc` = 0x14 with the word from 0x10; the next request is to 0x14.
- Branch to 0x100 while a 2-wait request to 0x20 is outstanding:
  - `imem_addr` stays 0x20 until ack, and that data never appears.
  - The next request goes to 0x100.
  - `if_pc` later equals 0x104.
- Branch together with freeze and a full skid: `if_valid` = 0 next cycle, the skid word is lost, and a request to the target issues.
- `rst` pulsed during DRAIN: outputs return to reset values; the first request after reset is to `RESET_PC`.
